// File: rtl/gate_sequencer.sv
// Parking gate sequencer: arbitrates entry/exit requests, tracks occupancy
// and closes the gate after a car passes or the open window times out.
module gate_sequencer #(
  parameter int CAPACITY   = 8,
  parameter int CNT_W      = 4,
  parameter int OPEN_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass,
  output logic             gate_open,
  output logic             dir_in,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout,
  output logic             busy
);

  localparam int TW = (OPEN_TICKS > 1) ? $clog2(OPEN_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [TW-1:0] TLAST = TW'(OPEN_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IN  = 2'd1,
    GRANT_OUT = 2'd2,
    CLOSE     = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          last_in;
  logic          elig_in;
  logic          elig_out;
  logic          pick_in;

  assign full     = (count == CAP);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign elig_in  = entry_req && !full;
  assign elig_out = exit_req && !empty;
  // On a tie, serve the direction not served last time.
  assign pick_in  = elig_in && (!elig_out || !last_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gate_open <= 1'b0;
      dir_in    <= 1'b0;
      count     <= '0;
      timeout   <= 1'b0;
      tcnt      <= '0;
      last_in   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (elig_in || elig_out) begin
            state     <= pick_in ? GRANT_IN : GRANT_OUT;
            gate_open <= 1'b1;
            dir_in    <= pick_in;
            last_in   <= pick_in;
            tcnt      <= '0;
          end
        end
        GRANT_IN, GRANT_OUT: begin
          if (pass) begin
            if (state == GRANT_IN && count != CAP)
              count <= count + 1'b1;
            else if (state == GRANT_OUT && count != '0)
              count <= count - 1'b1;
            state     <= CLOSE;
            gate_open <= 1'b0;
          end else if (tick) begin
            if (tcnt == TLAST) begin
              timeout   <= 1'b1;
              state     <= CLOSE;
              gate_open <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        CLOSE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: grants, round robin, full/empty,
// timeout, pass/tick collision and asynchronous reset mid-grant.
module tb_gate_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       entry_req;
  logic       exit_req;
  logic       pass;
  logic       gate_open;
  logic       dir_in;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       timeout;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  gate_sequencer #(
    .CAPACITY(8),
    .CNT_W(4),
    .OPEN_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .entry_req(entry_req),
    .exit_req(exit_req),
    .pass(pass),
    .gate_open(gate_open),
    .dir_in(dir_in),
    .count(count),
    .full(full),
    .empty(empty),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic car(input bit in);
    entry_req = in;
    exit_req  = !in;
    cyc();
    chk("car_open", gate_open, 1);
    chk("car_dir", dir_in, in);
    entry_req = 0;
    exit_req  = 0;
    pass = 1;
    cyc();
    pass = 0;
    exp_cnt = in ? exp_cnt + 1 : exp_cnt - 1;
    chk("car_cnt", count, exp_cnt);
    chk("car_close", gate_open, 0);
    cyc();
    chk("car_idle", busy, 0);
  endtask

  initial begin
    reset = 1; tick = 0; entry_req = 0; exit_req = 0; pass = 0;
    #12;
    chk("rst_open", gate_open, 0);
    chk("rst_dir", dir_in, 0);
    chk("rst_cnt", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_to", timeout, 0);
    reset = 0;
    cyc();

    // exit while empty and stray pass are ignored
    exit_req = 1;
    cyc();
    chk("empty_ign", busy, 0);
    exit_req = 0;
    pass = 1;
    cyc();
    pass = 0;
    chk("pass_idle", count, 0);

    // single entry, pass five cycles later
    entry_req = 1;
    cyc();
    chk("e_open", gate_open, 1);
    chk("e_dir", dir_in, 1);
    entry_req = 0;
    repeat (4) begin
      cyc();
      chk("e_hold", gate_open, 1);
    end
    pass = 1;
    cyc();
    pass = 0;
    chk("e_cnt", count, 1);
    chk("e_close", gate_open, 0);
    chk("e_cbusy", busy, 1);
    cyc();
    chk("e_idle", busy, 0);
    exp_cnt = 1;

    // count to 2 with last served = exit
    car(1);
    car(1);
    car(0);

    // both held: IN, OUT, IN
    entry_req = 1;
    exit_req  = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_dir", dir_in, (i != 1));
      chk("rr_open", gate_open, 1);
      pass = 1;
      cyc();
      pass = 0;
      exp_cnt = (i != 1) ? exp_cnt + 1 : exp_cnt - 1;
      chk("rr_cnt", count, exp_cnt);
      cyc();
    end
    entry_req = 0;
    exit_req  = 0;
    chk("rr_final", count, 3);

    // fill to capacity
    repeat (5) car(1);
    chk("full", full, 1);
    entry_req = 1;
    cyc();
    chk("full_ign", busy, 0);
    chk("full_shut", gate_open, 0);
    entry_req = 0;
    car(0);
    chk("unfull", full, 0);
    chk("cnt7", count, 7);

    // timeout after three ticks
    entry_req = 1;
    cyc();
    entry_req = 0;
    chk("to_open", gate_open, 1);
    tick = 1; cyc(); tick = 0;
    cyc();
    tick = 1; cyc(); tick = 0;
    chk("to_pre", timeout, 0);
    tick = 1; cyc(); tick = 0;
    chk("to_pulse", timeout, 1);
    chk("to_close", gate_open, 0);
    chk("to_cnt", count, 7);
    cyc();
    chk("to_once", timeout, 0);
    chk("to_idle", busy, 0);

    // pass coincides with expiring tick
    exit_req = 1;
    cyc();
    exit_req = 0;
    chk("co_dir", dir_in, 0);
    tick = 1; cyc();
    cyc();
    pass = 1;
    cyc();
    tick = 0;
    pass = 0;
    chk("co_cnt", count, 6);
    chk("co_to", timeout, 0);
    chk("co_close", gate_open, 0);
    cyc();

    // asynchronous reset during GRANT_IN
    entry_req = 1;
    cyc();
    entry_req = 0;
    chk("ar_open", gate_open, 1);
    #2;
    reset = 1;
    #1;
    chk("ar_shut", gate_open, 0);
    chk("ar_cnt", count, 0);
    chk("ar_busy", busy, 0);
    reset = 0;
    cyc();
    chk("ar_stay", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
